e203_dtcm_sram_ctrl: RTL and testbench

- Downstream stage of the DTCM ICB arbiter. It takes the single arbitrated ICB command stream and drives the DTCM SRAM macro's chip-select, write-enable, address, byte-mask and write data.
- It returns one ICB response per accepted command. SRAM read latency is fixed at 1 cycle.
- A one-entry hold register keeps response data stable while the response is back-pressured, so the core LSU or the external agent can stall without losing read data.
- It also produces a clock-enable for the SRAM clock and an activity flag for core clock-gating.

---
 rtl/e203_dtcm_pkg.sv | 15 +
 rtl/e203_dtcm_sram_ctrl.sv | 107 ++++++++++
 tb/tb_e203_dtcm_sram_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/e203_dtcm_pkg.sv
// Shared constants and state encoding for the DTCM SRAM controller.
package e203_dtcm_pkg;

    localparam int DTCM_AW     = 16;
    localparam int DTCM_DW     = 32;
    localparam int DTCM_MW     = DTCM_DW / 8;
    localparam int DTCM_AW_LSB = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RSP  = 2'd1,
        HOLD = 2'd2
    } sram_state_e;

endpackage

// File: rtl/e203_dtcm_sram_ctrl.sv
// DTCM SRAM controller: turns one ICB command stream into SRAM accesses and
// returns one response per command, holding read data across back-pressure.
module e203_dtcm_sram_ctrl
    import e203_dtcm_pkg::*;
#(
    parameter int AW     = DTCM_AW,
    parameter int DW     = DTCM_DW,
    parameter int MW     = DTCM_MW,
    parameter int AW_LSB = DTCM_AW_LSB,
    parameter int RAW    = AW - AW_LSB
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tcm_cgstop,
    input  logic          i_icb_cmd_valid,
    output logic          i_icb_cmd_ready,
    input  logic          i_icb_cmd_read,
    input  logic [AW-1:0] i_icb_cmd_addr,
    input  logic [DW-1:0] i_icb_cmd_wdata,
    input  logic [MW-1:0] i_icb_cmd_wmask,
    output logic          i_icb_rsp_valid,
    input  logic          i_icb_rsp_ready,
    output logic          i_icb_rsp_err,
    output logic [DW-1:0] i_icb_rsp_rdata,
    output logic          i_icb_rsp_read,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [RAW-1:0] ram_addr,
    output logic [MW-1:0] ram_wem,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          ram_clk_en,
    output logic          sram_ctrl_active
);

    sram_state_e   state_reg, state_next;
    logic [DW-1:0] hold_reg, hold_next;
    logic          read_reg, read_next;
    logic          acc;
    logic [DW-1:0] live_rdata;
    logic          unused_addr_lsb;

    // A new command may only enter when the owed response leaves this cycle.
    assign i_icb_cmd_ready = (state_reg == IDLE) ? 1'b1 : i_icb_rsp_ready;
    assign acc             = i_icb_cmd_valid & i_icb_cmd_ready;

    assign ram_cs   = acc;
    assign ram_we   = acc & ~i_icb_cmd_read;
    assign ram_addr = i_icb_cmd_addr[AW-1:AW_LSB];
    assign ram_din  = i_icb_cmd_wdata;

    generate
        for (genvar gi = 0; gi < MW; gi++) begin : g_wem
            assign ram_wem[gi] = ~i_icb_cmd_read & i_icb_cmd_wmask[gi];
        end
    endgenerate

    assign unused_addr_lsb = ^i_icb_cmd_addr[AW_LSB-1:0];

    assign live_rdata       = read_reg ? ram_dout : '0;
    assign i_icb_rsp_valid  = (state_reg != IDLE);
    assign i_icb_rsp_rdata  = (state_reg == HOLD) ? hold_reg : live_rdata;
    assign i_icb_rsp_read   = read_reg;
    assign i_icb_rsp_err    = 1'b0;
    assign ram_clk_en       = acc | tcm_cgstop;
    assign sram_ctrl_active = i_icb_cmd_valid | (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        read_next  = read_reg;
        if (acc) begin
            read_next = i_icb_cmd_read;
        end
        unique case (state_reg)
            IDLE: begin
                if (acc) state_next = RSP;
            end
            RSP: begin
                if (i_icb_rsp_ready) begin
                    state_next = acc ? RSP : IDLE;
                end else begin
                    // ram_dout is only valid for one cycle; freeze it here.
                    hold_next  = live_rdata;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (i_icb_rsp_ready) state_next = acc ? RSP : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            hold_reg  <= '0;
            read_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
            read_reg  <= read_next;
        end
    end

endmodule

// File: tb/tb_e203_dtcm_sram_ctrl.sv
// Bench for e203_dtcm_sram_ctrl: SRAM model, reference memory scoreboard,
// table-driven command vectors and hand-written stall/reset/gating sequences.
module tb_e203_dtcm_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tcm_cgstop = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_read = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wmask = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        rsp_read;
    logic        ram_cs, ram_we, ram_clk_en, active;
    logic [13:0] ram_addr;
    logic [3:0]  ram_wem;
    logic [31:0] ram_din;
    logic [31:0] ram_dout = '0;
    logic        corrupt = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    e203_dtcm_sram_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .tcm_cgstop       (tcm_cgstop),
        .i_icb_cmd_valid  (cmd_valid),
        .i_icb_cmd_ready  (cmd_ready),
        .i_icb_cmd_read   (cmd_read),
        .i_icb_cmd_addr   (cmd_addr),
        .i_icb_cmd_wdata  (cmd_wdata),
        .i_icb_cmd_wmask  (cmd_wmask),
        .i_icb_rsp_valid  (rsp_valid),
        .i_icb_rsp_ready  (rsp_ready),
        .i_icb_rsp_err    (rsp_err),
        .i_icb_rsp_rdata  (rsp_rdata),
        .i_icb_rsp_read   (rsp_read),
        .ram_cs           (ram_cs),
        .ram_we           (ram_we),
        .ram_addr         (ram_addr),
        .ram_wem          (ram_wem),
        .ram_din          (ram_din),
        .ram_dout         (ram_dout),
        .ram_clk_en       (ram_clk_en),
        .sram_ctrl_active (active)
    );

    // SRAM macro model: 1-cycle read latency, garbage output when asked to corrupt.
    logic [31:0] sram_mem [0:16383];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wem[b]) sram_mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            end else begin
                ram_dout <= sram_mem[ram_addr];
            end
        end else if (corrupt) begin
            ram_dout <= $urandom;
        end
    end

    // Scoreboard: expected response computed from a byte-level reference memory.
    typedef struct {
        logic        read;
        logic [31:0] rdata;
    } exp_t;
    exp_t        sb_q[$];
    exp_t        sb_e;
    logic [31:0] ref_mem [0:16383];
    logic [13:0] ref_w;

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL rsp_unexpected actual rdata=%h read=%b required no response", rsp_rdata, rsp_read);
                end else begin
                    sb_e = sb_q.pop_front();
                    if (rsp_rdata !== sb_e.rdata || rsp_read !== sb_e.read || rsp_err !== 1'b0) begin
                        failures++;
                        $display("FAIL rsp actual rdata=%h read=%b err=%b required rdata=%h read=%b err=0",
                                 rsp_rdata, rsp_read, rsp_err, sb_e.rdata, sb_e.read);
                    end else begin
                        $display("rsp read=%b rdata=%h t=%0t", rsp_read, rsp_rdata, $time);
                    end
                end
            end
            if (cmd_valid && cmd_ready) begin
                ref_w = cmd_addr[15:2];
                sb_e.read  = cmd_read;
                sb_e.rdata = cmd_read ? ref_mem[ref_w] : 32'h0;
                if (!cmd_read)
                    for (int b = 0; b < 4; b++)
                        if (cmd_wmask[b]) ref_mem[ref_w][8*b +: 8] = cmd_wdata[8*b +: 8];
                sb_q.push_back(sb_e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
        cmd_valid = 1'b1;
        cmd_read  = rd;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wmask = m;
    endtask

    typedef struct {
        logic        read;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [13:0] e_addr;
        logic        e_we;
        logic [3:0]  e_wem;
    } vec_t;
    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16384; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        vecs[0] = '{1'b0, 16'h0010, 32'hDEADBEEF, 4'hF, 14'h0004, 1'b1, 4'hF};
        vecs[1] = '{1'b1, 16'h0010, 32'h0,        4'hF, 14'h0004, 1'b0, 4'h0};
        vecs[2] = '{1'b0, 16'h0010, 32'h000000AA, 4'h1, 14'h0004, 1'b1, 4'h1};
        vecs[3] = '{1'b1, 16'h0010, 32'h0,        4'h0, 14'h0004, 1'b0, 4'h0};
        vecs[4] = '{1'b0, 16'h0020, 32'h12345678, 4'h0, 14'h0008, 1'b1, 4'h0};
        vecs[5] = '{1'b1, 16'h0020, 32'h0,        4'h0, 14'h0008, 1'b0, 4'h0};
        vecs[6] = '{1'b0, 16'h0026, 32'hCAFEF00D, 4'hC, 14'h0009, 1'b1, 4'hC};
        vecs[7] = '{1'b1, 16'h0027, 32'h0,        4'h0, 14'h0009, 1'b0, 4'h0};
        vecs[8] = '{1'b1, 16'hFFFC, 32'hFFFFFFFF, 4'hF, 14'h3FFF, 1'b0, 4'h0};

        // Reset state
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_ram_cs", 32'(ram_cs), 32'd0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_active", 32'(active), 32'd0);
        chk("idle_clk_en", 32'(ram_clk_en), 32'd0);
        step();

        // Table-driven commands, fully pipelined with rsp_ready=1
        foreach (vecs[i]) begin
            drive(vecs[i].read, vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
            @(negedge clk);
            checks++;
            if (ram_cs !== 1'b1 || ram_we !== vecs[i].e_we || ram_addr !== vecs[i].e_addr ||
                ram_wem !== vecs[i].e_wem || ram_din !== vecs[i].wdata || ram_clk_en !== 1'b1) begin
                failures++;
                $display("FAIL vec%0d actual cs=%b we=%b addr=%h wem=%h din=%h ce=%b required cs=1 we=%b addr=%h wem=%h din=%h ce=1",
                         i, ram_cs, ram_we, ram_addr, ram_wem, ram_din, ram_clk_en,
                         vecs[i].e_we, vecs[i].e_addr, vecs[i].e_wem, vecs[i].wdata);
            end else begin
                $display("cmd vec%0d read=%b addr=%h", i, vecs[i].read, vecs[i].addr);
            end
            step();
        end
        cmd_valid = 1'b0;
        step(); step();

        // Back-pressure: read stalls 3 cycles while ram_dout is corrupted
        drive(1'b1, 16'h0010, 32'h0, 4'h0);
        rsp_ready = 1'b0;
        step();
        drive(1'b1, 16'h0020, 32'h0, 4'h0);
        corrupt = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rdata", rsp_rdata, 32'hDEADBEAA);
            chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("stall_ram_cs", 32'(ram_cs), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_cs", 32'(ram_cs), 32'd1);
        step();
        cmd_valid = 1'b0;
        corrupt = 1'b0;
        step(); step();

        // Streaming: 8 writes then 8 reads, one per cycle
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 16'(16'h0040 + 4 * i), 32'(32'h10000000 + 32'h111 * i), 4'hF);
            step();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(16'h0040 + 4 * i), 32'h0, 4'h0);
            @(negedge clk);
            chk("stream_rsp_valid", 32'(rsp_valid), 32'd1);
            step();
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("stream_last_rsp", 32'(rsp_valid), 32'd1);
        step();
        @(negedge clk);
        chk("stream_drained", 32'(rsp_valid), 32'd0);
        step();

        // Reset mid-operation while in HOLD, with a competing command
        drive(1'b1, 16'h0010, 32'h0, 4'h0);
        rsp_ready = 1'b0;
        step();
        cmd_valid = 1'b0;
        step();
        rst = 1'b1;
        cmd_valid = 1'b1;
        step();
        rst = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_mid_active", 32'(active), 32'd0);
        step();

        // Clock gating override
        tcm_cgstop = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("cgstop_clk_en", 32'(ram_clk_en), 32'd1);
            step();
        end
        tcm_cgstop = 1'b0;
        @(negedge clk);
        chk("cg_idle_clk_en", 32'(ram_clk_en), 32'd0);
        step(); step();

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
